dct_row_mem_ctrl: RTL and testbench
===================================

Name: dct_row_mem_ctrl

Overview:
- Frame sequencer for the row-DCT stage.
- Streams a programmable run of 128-bit words from the input RF memory (16384x128, mux-16) into DCT_1D_row.
- Tracks the fixed memory and DCT pipeline latency, and writes each 176-bit DCT result, zero-extended to 192 bits, into the output RF memory (16384x192).
- Replaces the free-running address counter used for bring-up; the top level instantiates the memories and DCT and wires them to this block.

Parameters:
- MEM_LAT, 1, cycles from read address/NCE at memory pins to valid read data.
- DCT_LAT, 3, cycles from DCT input to matching DCT output.
- AW, 14, word-address width; RA is AW-4 bits, CA is 4 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; ignored while busy.
- base_in  in  14  first input-memory word address; latched at start.
- base_out  in  14  first output-memory word address; latched at start.
- num_words  in  15  words in frame, 0..16384; latched at start.
- rd_nce  out  1  input-memory chip enable, active low.
- rd_nwrt  out  1  input-memory write enable, active low; tied 1.
- rd_ra  out  10  input-memory row address, word address [13:4].
- rd_ca  out  4  input-memory column address, word address [3:0].
- dct_out  in  176  DCT_1D_row X_k output.
- wr_nce  out  1  output-memory chip enable, active low.
- wr_nwrt  out  1  output-memory write enable, active low.
- wr_ra  out  10  output-memory row address.
- wr_ca  out  4  output-memory column address.
- wr_data  out  192  {16'b0, dct_out}.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Interface: clock port is clk; reset port is reset, synchronous, active-high.
- All outputs are registered except wr_data, which is combinational from dct_out.
- Reset values: rd_nce=1, rd_nwrt=1, rd_ra=0, rd_ca=0, wr_nce=1, wr_nwrt=1, wr_ra=0, wr_ca=0, busy=0, done=0.
- Reset also clears: state=IDLE, read counter, write counter, and the valid pipe of L=MEM_LAT+DCT_LAT bits.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 with num_words>0: latch inputs; rd_cnt=0, wr_cnt=0; go to READ.
  - start=1 with num_words=0: go to FIN directly; no memory access occurs.
- READ:
  - Each cycle: rd_nce=0, {rd_ra,rd_ca} = base_in + rd_cnt (mod 2^14, wraps 16383->0); push 1 into the valid pipe; rd_cnt++.
  - After num_words issues, go to DRAIN; rd_nce returns to 1 on the next cycle.
- DRAIN: push 0s into the valid pipe. When wr_cnt reaches num_words, go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- Write timing: the valid pipe tail marks the cycle in which dct_out holds the result for the read issued L cycles earlier.
  - In that cycle: wr_nce=0, wr_nwrt=0, {wr_ra,wr_ca} = base_out + wr_cnt (mod 2^14); wr_cnt++.
  - Otherwise: wr_nce=1, wr_nwrt=1.
  - Writes from one frame are strictly consecutive cycles.
- Cycle timing, with cycle 0 = the cycle start is sampled high:
  - Reads occupy cycles 1..N.
  - Writes occupy cycles 1+L..N+L.
  - done pulses in cycle N+L+1.
  - busy=1 in cycles 1..N+L+1, and falls in the same cycle done falls.
- start during READ, DRAIN or FIN: ignored; latched values do not change.
- start in the cycle after done: accepted; back-to-back frames are allowed.
- num_words > 16384: clamped to 16384.
- The block does not reset or stall the DCT. The DCT pipeline runs freely; outputs outside write slots are discarded.
- Reset asserted mid-frame: all outputs take reset values on the next cycle, pending writes are dropped, and no done pulse is produced.

Test Plan:
- Reset: hold reset 3 cycles -> all outputs at reset values, rd_nce=wr_nce=1, busy=0.
- Basic frame (L=4): base_in=0, base_out=100, N=4 ->
  - reads at addresses 0..3 in cycles 1..4;
  - writes at 100..103 in cycles 5..8, with wr_data = {16'b0, dct_out} each cycle;
  - done in cycle 9 only.
- Wrap-around: base_in=16382, base_out=16383, N=3 ->
  - read RA/CA sequence (1023,14), (1023,15), (0,0);
  - write sequence 16383, 0, 1.
- Zero length and ignored start: N=0 -> no rd_nce/wr_nce low, done in cycle 1. Then start re-asserted during READ of an N=8 frame -> exactly 8 reads and 8 writes occur, and base values are unchanged.
- Back-to-back frames: start in the cycle after done -> second frame reads start in the next cycle with the new base values; the write count across both frames equals N1+N2.
- Mid-frame reset: reset in cycle 3 of an N=10 frame -> rd_nce=1 in cycle 4, no writes occur, no done pulse; a subsequent start runs a clean frame.

Source files
------------

// File: rtl/dct_row_mem_ctrl.sv
// dct_row_mem_ctrl: frame sequencer for the row-DCT stage. It streams a run of words from the
// input RF into DCT_1D_row and writes the delayed DCT results into the output RF.
`default_nettype none

module dct_row_mem_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int DCT_LAT = 3,
  parameter int AW      = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_in,
  input  logic [AW-1:0] base_out,
  input  logic [AW:0]   num_words,
  output logic          rd_nce,
  output logic          rd_nwrt,
  output logic [AW-5:0] rd_ra,
  output logic [3:0]    rd_ca,
  input  logic [175:0]  dct_out,
  output logic          wr_nce,
  output logic          wr_nwrt,
  output logic [AW-5:0] wr_ra,
  output logic [3:0]    wr_ca,
  output logic [191:0]  wr_data,
  output logic          busy,
  output logic          done
);

  localparam int         L         = MEM_LAT + DCT_LAT;
  localparam logic [AW:0] MAX_WORDS = (AW+1)'(1) << AW;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t        state_q;
  logic [AW-1:0] base_in_q, base_out_q;
  logic [AW:0]   n_q, rd_cnt_q, wr_cnt_q;
  logic [L-1:0]  vpipe_q, vpipe_d;
  logic [AW:0]   n_clamp;
  logic          push;
  logic [AW-1:0] rd_addr, wr_addr;

  assign n_clamp = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign push    = ((state_q == IDLE) && start && (num_words != '0)) ||
                   ((state_q == READ) && (rd_cnt_q < n_q));
  assign rd_addr = base_in_q + rd_cnt_q[AW-1:0];
  assign wr_addr = base_out_q + wr_cnt_q[AW-1:0];
  assign rd_nwrt = 1'b1;
  assign wr_data = {16'b0, dct_out};

  // The tail bit of the valid pipe lines up with the DCT result of the read issued L cycles earlier.
  always_comb begin
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_in_q  <= '0;
      base_out_q <= '0;
      n_q        <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      vpipe_q    <= '0;
      rd_nce     <= 1'b1;
      rd_ra      <= '0;
      rd_ca      <= '0;
      wr_nce     <= 1'b1;
      wr_nwrt    <= 1'b1;
      wr_ra      <= '0;
      wr_ca      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vpipe_q <= vpipe_d;
      done    <= 1'b0;

      if (vpipe_q[L-1]) begin
        wr_nce          <= 1'b0;
        wr_nwrt         <= 1'b0;
        {wr_ra, wr_ca}  <= wr_addr;
        wr_cnt_q        <= wr_cnt_q + 1'b1;
      end else begin
        wr_nce  <= 1'b1;
        wr_nwrt <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_words == '0) begin
              done    <= 1'b1;
              state_q <= FIN;
            end else begin
              base_in_q      <= base_in;
              base_out_q     <= base_out;
              n_q            <= n_clamp;
              rd_nce         <= 1'b0;
              {rd_ra, rd_ca} <= base_in;
              rd_cnt_q       <= (AW+1)'(1);
              wr_cnt_q       <= '0;
              state_q        <= READ;
            end
          end
        end
        READ: begin
          if (rd_cnt_q < n_q) begin
            rd_nce         <= 1'b0;
            {rd_ra, rd_ca} <= rd_addr;
            rd_cnt_q       <= rd_cnt_q + 1'b1;
          end else begin
            rd_nce  <= 1'b1;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (wr_cnt_q == n_q) begin
            done    <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dct_row_mem_ctrl.sv
// Directed bench for dct_row_mem_ctrl with the default latencies (L = 4).
`default_nettype none

module tb_dct_row_mem_ctrl;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [13:0]  base_in, base_out;
  logic [14:0]  num_words;
  logic [175:0] dct_out;
  logic         rd_nce, rd_nwrt, wr_nce, wr_nwrt, busy, done;
  logic [9:0]   rd_ra, wr_ra;
  logic [3:0]   rd_ca, wr_ca;
  logic [191:0] wr_data;

  int vec  = 0;
  int errs = 0;

  dct_row_mem_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .base_in(base_in), .base_out(base_out),
    .num_words(num_words), .rd_nce(rd_nce), .rd_nwrt(rd_nwrt), .rd_ra(rd_ra), .rd_ca(rd_ca),
    .dct_out(dct_out), .wr_nce(wr_nce), .wr_nwrt(wr_nwrt), .wr_ra(wr_ra), .wr_ca(wr_ca),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic new_dct();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    dct_out = t[175:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({rd_nce, rd_nwrt, wr_nce, wr_nwrt, busy, done} !== 6'b111100) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 111100", {rd_nce, rd_nwrt, wr_nce, wr_nwrt, busy, done});
    end
    vec++;
    if ({rd_ra, rd_ca, wr_ra, wr_ca} !== 28'd0) begin
      errs++;
      $display("FAIL reset_addr: got %h want 0", {rd_ra, rd_ca, wr_ra, wr_ca});
    end
    reset = 1'b0;
  endtask

  task automatic test_frame(input string name, input logic [13:0] bi, input logic [13:0] bo,
                            input logic [14:0] n);
    int          last;
    logic        er, ew;
    logic [5:0]  ectl;
    logic [13:0] ea;
    last = (n == 0) ? 1 : int'(n) + L + 1;
    @(negedge clk);
    base_in = bi; base_out = bo; num_words = n; start = 1'b1;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      er = (c <= int'(n));
      ew = (c >= 1 + L) && (c <= int'(n) + L);
      ectl = {~er, 1'b1, ~ew, ~ew, (c <= last), (c == last)};
      vec++;
      if ({rd_nce, rd_nwrt, wr_nce, wr_nwrt, busy, done} !== ectl) begin
        errs++;
        $display("FAIL %s ctl c=%0d: got %b want %b", name, c,
                 {rd_nce, rd_nwrt, wr_nce, wr_nwrt, busy, done}, ectl);
      end
      if (er) begin
        ea = 14'(int'(bi) + c - 1);
        vec++;
        if ({rd_ra, rd_ca} !== ea) begin
          errs++;
          $display("FAIL %s rd_addr c=%0d: got %0d want %0d", name, c, {rd_ra, rd_ca}, ea);
        end
      end
      if (ew) begin
        ea = 14'(int'(bo) + c - 1 - L);
        vec++;
        if ({wr_ra, wr_ca} !== ea) begin
          errs++;
          $display("FAIL %s wr_addr c=%0d: got %0d want %0d", name, c, {wr_ra, wr_ca}, ea);
        end
        vec++;
        if (wr_data !== {16'b0, dct_out}) begin
          errs++;
          $display("FAIL %s wr_data c=%0d: got %h want %h", name, c, wr_data, {16'b0, dct_out});
        end
      end
      new_dct();
    end
  endtask

  task automatic test_wrap();
    // Hand values: reads (1023,14),(1023,15),(0,0); writes 16383,0,1.
    logic [13:0] rd_exp [3];
    logic [13:0] wr_exp [3];
    int nr, nw;
    rd_exp = '{14'd16382, 14'd16383, 14'd0};
    wr_exp = '{14'd16383, 14'd0, 14'd1};
    nr = 0; nw = 0;
    @(negedge clk);
    base_in = 14'd16382; base_out = 14'd16383; num_words = 15'd3; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!rd_nce && nr < 3) begin
        vec++;
        if ({rd_ra, rd_ca} !== rd_exp[nr]) begin
          errs++;
          $display("FAIL wrap rd %0d: got (%0d,%0d) want %0d", nr, rd_ra, rd_ca, rd_exp[nr]);
        end
        nr++;
      end
      if (!wr_nce && nw < 3) begin
        vec++;
        if ({wr_ra, wr_ca} !== wr_exp[nw]) begin
          errs++;
          $display("FAIL wrap wr %0d: got %0d want %0d", nw, {wr_ra, wr_ca}, wr_exp[nw]);
        end
        nw++;
      end
    end
    vec++;
    if (nr !== 3 || nw !== 3) begin
      errs++;
      $display("FAIL wrap counts: got rd=%0d wr=%0d want 3/3", nr, nw);
    end
  endtask

  task automatic test_ignored_start();
    int nr, nw, nd;
    nr = 0; nw = 0; nd = 0;
    @(negedge clk);
    base_in = 14'd40; base_out = 14'd200; num_words = 15'd8; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!rd_nce) begin
        vec++;
        if ({rd_ra, rd_ca} !== 14'(40 + nr)) begin
          errs++;
          $display("FAIL ign rd_addr: got %0d want %0d", {rd_ra, rd_ca}, 40 + nr);
        end
        nr++;
      end
      if (!wr_nce) begin
        vec++;
        if ({wr_ra, wr_ca} !== 14'(200 + nw)) begin
          errs++;
          $display("FAIL ign wr_addr: got %0d want %0d", {wr_ra, wr_ca}, 200 + nw);
        end
        nw++;
      end
      if (done) nd++;
      if (c == 2 || c == 3) begin
        base_in = 14'd7000; base_out = 14'd9000; num_words = 15'd3; start = 1'b1;
      end
    end
    vec++;
    if (nr !== 8 || nw !== 8 || nd !== 1) begin
      errs++;
      $display("FAIL ign counts: got rd=%0d wr=%0d done=%0d want 8/8/1", nr, nw, nd);
    end
  endtask

  task automatic test_back_to_back();
    int          nr, nw;
    logic        ew, ed;
    logic [13:0] ea;
    nr = 0; nw = 0;
    @(negedge clk);
    base_in = 14'd10; base_out = 14'd50; num_words = 15'd3; start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      start = 1'b0;
      ed = (c == 8) || (c == 19);
      vec++;
      if (done !== ed) begin
        errs++;
        $display("FAIL b2b done c=%0d: got %b want %b", c, done, ed);
      end
      if (c == 10) begin
        vec++;
        if (rd_nce !== 1'b0 || {rd_ra, rd_ca} !== 14'd500) begin
          errs++;
          $display("FAIL b2b first_rd: got nce=%b addr=%0d want 0/500", rd_nce, {rd_ra, rd_ca});
        end
      end
      ew = (c >= 5 && c <= 7) || (c >= 14 && c <= 18);
      ea = (c <= 7) ? 14'(50 + c - 5) : 14'(900 + c - 14);
      if (ew) begin
        vec++;
        if (wr_nce !== 1'b0 || {wr_ra, wr_ca} !== ea) begin
          errs++;
          $display("FAIL b2b wr c=%0d: got nce=%b addr=%0d want 0/%0d", c, wr_nce, {wr_ra, wr_ca}, ea);
        end
      end
      if (!rd_nce) nr++;
      if (!wr_nce) nw++;
      if (c == 9) begin
        base_in = 14'd500; base_out = 14'd900; num_words = 15'd5; start = 1'b1;
      end
    end
    vec++;
    if (nr !== 8 || nw !== 8) begin
      errs++;
      $display("FAIL b2b counts: got rd=%0d wr=%0d want 8/8", nr, nw);
    end
  endtask

  task automatic test_mid_reset();
    int nw, nd;
    nw = 0; nd = 0;
    @(negedge clk);
    base_in = 14'd0; base_out = 14'd0; num_words = 15'd10; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin
        vec++;
        if (rd_nce !== 1'b0) begin
          errs++;
          $display("FAIL mid_reset pre: got rd_nce=%b want 0", rd_nce);
        end
        reset = 1'b1;
      end else if (c == 4) begin
        vec++;
        if ({rd_nce, busy} !== 2'b10) begin
          errs++;
          $display("FAIL mid_reset post: got rd_nce/busy=%b want 10", {rd_nce, busy});
        end
        reset = 1'b0;
      end
      if (c >= 4 && !wr_nce) nw++;
      if (c >= 4 && done) nd++;
    end
    vec++;
    if (nw !== 0 || nd !== 0) begin
      errs++;
      $display("FAIL mid_reset quiet: got wr=%0d done=%0d want 0/0", nw, nd);
    end
    test_frame("post_reset", 14'd5, 14'd6, 15'd2);
  endtask

  task automatic test_clamp();
    int nr, nw, dc;
    nr = 0; nw = 0; dc = 0;
    @(negedge clk);
    base_in = 14'd0; base_out = 14'd0; num_words = 15'd20000; start = 1'b1;
    for (int c = 1; c <= 16384 + 20 && dc == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!rd_nce) nr++;
      if (!wr_nce) nw++;
      if (done) dc = c;
    end
    vec++;
    if (nr !== 16384 || nw !== 16384 || dc !== 16384 + L + 1) begin
      errs++;
      $display("FAIL clamp: got rd=%0d wr=%0d done_cycle=%0d want 16384/16384/%0d",
               nr, nw, dc, 16384 + L + 1);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_in = '0; base_out = '0; num_words = '0; dct_out = '0;
    test_reset();
    test_frame("basic", 14'd0, 14'd100, 15'd4);
    test_wrap();
    test_frame("zero_len", 14'd77, 14'd88, 15'd0);
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
